// File: rtl/input_route_ctrl_pkg.sv
// Shared flit-format, port-index and FSM encodings for the router input stage.
// Combinational definitions only; no latency.
// No flow control of its own.
package input_route_ctrl_pkg;

    localparam int FLIT_W    = 16;
    localparam int NUM_PORTS = 5;

    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 14;
    localparam int DX_HI   = 13;
    localparam int DX_LO   = 11;
    localparam int DY_HI   = 10;
    localparam int DY_LO   = 8;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    typedef enum logic [1:0] {
        FLIT_SINGLE = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_REQ   = 2'd2,
        ST_FWD   = 2'd3
    } state_e;

    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[TYPE_HI:TYPE_LO]);
    endfunction

endpackage

// File: rtl/input_route_ctrl_xy_route_calc.sv
// Dimension-ordered XY route: resolve X first, then Y, else eject locally.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module xy_route_calc
    import input_route_ctrl_pkg::*;
(
    input  logic [2:0]           dst_x,
    input  logic [2:0]           dst_y,
    input  logic [2:0]           x_id,
    input  logic [2:0]           y_id,
    output logic [NUM_PORTS-1:0] port_onehot
);

    always_comb begin
        port_onehot = '0;
        if (dst_x > x_id)
            port_onehot[PORT_E] = 1'b1;
        else if (dst_x < x_id)
            port_onehot[PORT_W] = 1'b1;
        else if (dst_y > y_id)
            port_onehot[PORT_N] = 1'b1;
        else if (dst_y < y_id)
            port_onehot[PORT_S] = 1'b1;
        else
            port_onehot[PORT_L] = 1'b1;
    end

endmodule

// File: rtl/input_route_ctrl.sv
// Router input controller: routes a packet from the input FIFO, requests a port, forwards to tail.
// Latency: head at queue cycle 0 -> request cycle 2 -> first transfer cycle 3 with immediate grant.
// Backpressure: pops only on out_valid & out_ready; FIFO empty stalls in place.
module input_route_ctrl
    import input_route_ctrl_pkg::*;
#(
    parameter logic [2:0] X_ID = 3'd0,
    parameter logic [2:0] Y_ID = 3'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FLIT_W-1:0]    fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    output logic [NUM_PORTS-1:0] out_req,
    input  logic                 out_grant,
    output logic [FLIT_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          pkt_cnt,
    output logic                 err
);

    state_e                 state;
    logic [2:0]             dst_x;
    logic [2:0]             dst_y;
    logic                   first_sent;
    logic [NUM_PORTS-1:0]   route_onehot;
    flit_type_e             head_type;
    logic                   is_head_type;
    logic                   xfer;
    logic                   discard;

    assign head_type    = flit_type(fifo_data);
    assign is_head_type = (head_type == FLIT_HEAD) || (head_type == FLIT_SINGLE);
    assign out_data     = fifo_data;
    assign out_valid    = (state == ST_FWD) && !fifo_empty;
    assign xfer         = out_valid && out_ready;
    assign discard      = (state == ST_IDLE) && !fifo_empty && !is_head_type;
    // Reset also masks the pop so an orphan flit is not drained while reset is held.
    assign fifo_read    = reset && (xfer || discard);

    xy_route_calc u_route (
        .dst_x       (dst_x),
        .dst_y       (dst_y),
        .x_id        (X_ID),
        .y_id        (Y_ID),
        .port_onehot (route_onehot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            out_req    <= '0;
            pkt_cnt    <= '0;
            err        <= 1'b0;
            dst_x      <= '0;
            dst_y      <= '0;
            first_sent <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (is_head_type) begin
                            dst_x <= fifo_data[DX_HI:DX_LO];
                            dst_y <= fifo_data[DY_HI:DY_LO];
                            state <= ST_ROUTE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_ROUTE: begin
                    out_req <= route_onehot;
                    state   <= ST_REQ;
                end
                ST_REQ: begin
                    if (out_grant) begin
                        first_sent <= 1'b0;
                        state      <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    // Grant is not re-checked: the port is owned until the tail leaves.
                    if (xfer) begin
                        first_sent <= 1'b1;
                        if (head_type == FLIT_HEAD && first_sent)
                            err <= 1'b1;
                        if (head_type == FLIT_TAIL || head_type == FLIT_SINGLE) begin
                            pkt_cnt <= pkt_cnt + 16'd1;
                            out_req <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_route_ctrl.sv
// Directed bench for input_route_ctrl at mesh position (2,2) with a queue-based FIFO model.
module tb_input_route_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read;
    logic [4:0]  out_req;
    logic        out_grant = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] pkt_cnt;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [15:0] q[$];
    logic [15:0] dlv[$];
    logic        gap = 1'b0;
    logic        obs_read;
    logic        obs_valid;
    logic [15:0] obs_data;
    logic [4:0]  obs_req;

    always #5 clk = ~clk;

    input_route_ctrl #(.X_ID(3'd2), .Y_ID(3'd2)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .out_req    (out_req),
        .out_grant  (out_grant),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_cnt    (pkt_cnt),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc();
        fifo_empty = gap || (q.size() == 0);
        fifo_data  = (q.size() > 0) ? q[0] : 16'h0000;
        #1;
        obs_read  = fifo_read;
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_req   = out_req;
        if (obs_read && obs_valid)
            dlv.push_back(obs_data);
        @(posedge clk);
        if (obs_read && q.size() > 0)
            void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        q.delete();
        dlv.delete();
        q.push_back(a);
        q.push_back(b);
        q.push_back(c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rdy_tab [6];
        logic       gap_tab [6];
        logic       rd_tab  [6];
        logic       vld_tab [6];
        logic [15:0] sgl_tab [3];
        logic [4:0]  req_tab [3];
        rdy_tab = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gap_tab = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rd_tab  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vld_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        sgl_tab = '{16'h0200, 16'h1400, 16'h1100};
        req_tab = '{5'b10000, 5'b00010, 5'b01000};

        // Reset state
        #2;
        chk("rst_req", out_req, 5'b00000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_read", fifo_read, 1'b0);
        chk("rst_pkt", pkt_cnt, 16'd0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single flit to E, immediate grant
        q.push_back(16'h1A55);
        out_grant = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("t1_c0_read", obs_read, 1'b0);
        chk("t1_c0_req", obs_req, 5'b00000);
        cyc();
        chk("t1_c1_req", obs_req, 5'b00000);
        cyc();
        chk("t1_c2_req", obs_req, 5'b00100);
        chk("t1_c2_valid", obs_valid, 1'b0);
        cyc();
        chk("t1_c3_valid", obs_valid, 1'b1);
        chk("t1_c3_data", obs_data, 16'h1A55);
        chk("t1_c3_read", obs_read, 1'b1);
        cyc();
        chk("t1_c4_req", obs_req, 5'b00000);
        chk("t1_c4_valid", obs_valid, 1'b0);
        chk("t1_pkt", pkt_cnt, 16'd1);

        // Local 3-flit packet, grant held off 4 cycles then dropped during forwarding
        load3(16'h5200, 16'h8001, 16'hC002);
        out_grant = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_wait_req", obs_req, 5'b00001);
            chk("t2_wait_read", obs_read, 1'b0);
        end
        out_grant = 1'b1;
        cyc();
        chk("t2_grant_req", obs_req, 5'b00001);
        out_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_fwd_req", obs_req, 5'b00001);
            chk("t2_fwd_read", obs_read, 1'b1);
        end
        cyc();
        chk("t2_end_req", obs_req, 5'b00000);
        chk("t2_dlv_n", dlv.size(), 3);
        if (dlv.size() == 3) begin
            chk("t2_dlv0", dlv[0], 16'h5200);
            chk("t2_dlv1", dlv[1], 16'h8001);
            chk("t2_dlv2", dlv[2], 16'hC002);
        end
        chk("t2_pkt", pkt_cnt, 16'd2);

        // Same packet with ready toggling and an empty gap
        load3(16'h5200, 16'h8001, 16'hC002);
        out_grant = 1'b1;
        out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        for (int i = 0; i < 6; i++) begin
            out_ready = rdy_tab[i];
            gap = gap_tab[i];
            cyc();
            chk("t3_read", obs_read, rd_tab[i]);
            chk("t3_valid", obs_valid, vld_tab[i]);
        end
        gap = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("t3_end_req", obs_req, 5'b00000);
        chk("t3_dlv_n", dlv.size(), 3);
        if (dlv.size() == 3) begin
            chk("t3_dlv0", dlv[0], 16'h5200);
            chk("t3_dlv1", dlv[1], 16'h8001);
            chk("t3_dlv2", dlv[2], 16'hC002);
        end
        chk("t3_pkt", pkt_cnt, 16'd3);
        chk("t3_err", err, 1'b0);

        // Orphan body flit in IDLE
        q.delete();
        q.push_back(16'h8001);
        cyc();
        chk("t4_read", obs_read, 1'b1);
        chk("t4_valid", obs_valid, 1'b0);
        cyc();
        chk("t4_err", err, 1'b1);
        chk("t4_idle_read", obs_read, 1'b0);
        cyc();
        chk("t4_err_sticky", err, 1'b1);

        // Asynchronous reset during forwarding, then orphan tail of the abandoned packet
        load3(16'h5200, 16'h8001, 16'hC002);
        for (int i = 0; i < 4; i++)
            cyc();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() > 0) ? q[0] : 16'h0000;
        #1;
        chk("t5_pre_valid", out_valid, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_req", out_req, 5'b00000);
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_read", fifo_read, 1'b0);
        chk("t5_pkt", pkt_cnt, 16'd0);
        chk("t5_err", err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("t5_orph0_read", obs_read, 1'b1);
        cyc();
        chk("t5_orph1_read", obs_read, 1'b1);
        cyc();
        chk("t5_q_empty", q.size(), 0);
        chk("t5_orph_err", err, 1'b1);
        chk("t5_orph_req", obs_req, 5'b00000);
        chk("t5_orph_pkt", pkt_cnt, 16'd0);

        // Route directions W, N, S with single flits after a fresh reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            q.push_back(sgl_tab[i]);
            cyc();
            cyc();
            cyc();
            chk("t6_req", obs_req, req_tab[i]);
            cyc();
            chk("t6_data", obs_data, sgl_tab[i]);
            cyc();
        end
        chk("t6_pkt", pkt_cnt, 16'd3);

        // Second head inside a packet flags err and is forwarded
        chk("t7_err_pre", err, 1'b0);
        load3(16'h5200, 16'h5201, 16'hC002);
        for (int i = 0; i < 7; i++)
            cyc();
        chk("t7_err", err, 1'b1);
        chk("t7_dlv_n", dlv.size(), 3);
        if (dlv.size() == 3)
            chk("t7_dlv1", dlv[1], 16'h5201);
        chk("t7_pkt", pkt_cnt, 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_route_ctrl.md
INPUT_ROUTE_CTRL -- requirements
Module: input_route_ctrl

Interface
REQ-001 Parameter X_ID, default 0, 3-bit mesh X coordinate of this router.
REQ-002 Parameter Y_ID, default 0, 3-bit mesh Y coordinate of this router.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 fifo_data  input  16  head-of-queue flit from the upstream input FIFO, show-ahead (valid whenever fifo_empty=0).
REQ-006 fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 fifo_read  output  1  pop strobe to the upstream FIFO.
REQ-008 out_req  output  5  one-hot output-port request: [0] local, [1] N, [2] E, [3] S, [4] W.
REQ-009 out_grant  input  1  crossbar grant for the currently requested port.
REQ-010 out_data  output  16  flit toward the crossbar.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  downstream accepts a flit this cycle.
REQ-013 pkt_cnt  output  16  count of packets fully forwarded, wrapping.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Flit type field [15:14]: 01 head, 10 body, 11 tail, 00 single (head+tail); head/single carry dst_x [13:11], dst_y [10:8], payload [7:0].
REQ-016 FSM states IDLE, ROUTE, REQ, FWD.
REQ-017 IDLE with fifo_empty=0 and type head/single: latch dst_x/dst_y, no pop, go ROUTE.
REQ-018 IDLE with fifo_empty=0 and type body/tail: pop (fifo_read=1) and discard, set err, stay IDLE.
REQ-019 ROUTE: XY routing in one cycle: dst_x>X_ID -> E; dst_x<X_ID -> W; else dst_y>Y_ID -> N; dst_y<Y_ID -> S; else local; register out_req one-hot, go REQ.
REQ-020 REQ: out_req held; out_grant=1 sampled at the clock edge -> FWD; otherwise remain in REQ.
REQ-021 FWD: out_valid = !fifo_empty; out_data = fifo_data; fifo_read = out_valid & out_ready (combinational).
REQ-022 FWD transfer of a tail or single flit: pkt_cnt increments, out_req clears, FSM returns to IDLE on the same edge.
REQ-023 FWD transfer of head/body: stay FWD; out_req held; a head flit arriving in FWD after the first flit sets err and is forwarded as body.
REQ-024 Minimum latency: head at queue in cycle 0, ROUTE cycle 1, out_req asserted cycle 2, granted cycle 2 -> head transferred cycle 3.
REQ-025 Outside FWD, out_valid=0 and fifo_read=0 except in the discard case (REQ-018).
REQ-026 out_grant deasserting during FWD has no effect; the packet holds its port until its tail.
REQ-027 pkt_cnt wraps 16'hFFFF -> 0 without setting err.
REQ-028 fifo_empty=1 in FWD stalls without leaving FWD; no flit is lost or duplicated.

Reset
REQ-029 reset=0: FSM IDLE, out_req=0, out_valid=0, fifo_read=0, out_data don't-care, pkt_cnt=0, err=0, latched destination=0.
REQ-030 Reset mid-packet abandons the packet; remaining FIFO flits are treated as an orphan packet (REQ-018) after release.
REQ-031 err clears only on reset.

Structure
REQ-032 Shared package holds flit-type codes, field bit positions, port-index constants and FSM state encoding.
REQ-033 One combinational sub-module xy_route_calc (dst_x, dst_y, X_ID, Y_ID -> 5-bit one-hot) is instantiated.

Verification (X_ID=2, Y_ID=2)
REQ-034 Single flit 16'h1A55 (dst 3,2), grant immediate, ready=1 -> out_req=5'b00100 cycle 2, out_data=16'h1A55 cycle 3, pkt_cnt=1, IDLE cycle 4.
REQ-035 Head 16'h5200 (dst 2,2), body 16'h8001, tail 16'hC002, grant delayed 4 cycles -> out_req=5'b00001 held until tail transfer, 3 pops in order.
REQ-036 Same 3-flit packet with out_ready toggling 1,0,1,0 and FIFO empty gap -> no pops while ready=0 or empty=1, flits delivered in order, unchanged.
REQ-037 Body 16'h8001 at queue in IDLE -> popped, out_valid=0, err=1 sticky.
REQ-038 reset=0 asserted during FWD of a 3-flit packet -> out_req=0, out_valid=0 asynchronously, pkt_cnt=0, FSM IDLE.
REQ-039 Head dst (0,2) and head dst (2,4) -> out_req=5'b10000 (W) and 5'b00010 (N) respectively.
